// File: rtl/sys_axi_master.sv
// sys_axi_master: bridges a single-outstanding system bus onto AXI3.
// Each request becomes one single-beat AXI transfer. A response watchdog
// acks with an error if the slave does not answer in time, and DRAIN then
// absorbs the late AXI traffic without acking it.
module sys_axi_master #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IW  = 12,
    parameter int TMO = 255
) (
    input  logic            clk,
    input  logic            rstn,
    // system bus request
    input  logic [AW-1:0]   sys_addr,
    input  logic [DW-1:0]   sys_wdata,
    input  logic [DW/8-1:0] sys_sel,
    input  logic            sys_wen,
    input  logic            sys_ren,
    // system bus response
    output logic [DW-1:0]   sys_rdata,
    output logic            sys_ack,
    output logic            sys_err,
    // AXI write address
    output logic [IW-1:0]   AWID,
    output logic [AW-1:0]   AWADDR,
    output logic [3:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    // AXI write data
    output logic [IW-1:0]   WID,
    output logic [DW-1:0]   WDATA,
    output logic [DW/8-1:0] WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    // AXI write response
    input  logic [IW-1:0]   BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY,
    // AXI read address
    output logic [IW-1:0]   ARID,
    output logic [AW-1:0]   ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    // AXI read data
    input  logic [IW-1:0]   RID,
    input  logic [DW-1:0]   RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY
);

    localparam int            SW        = DW / 8;
    localparam int            CW        = $clog2(TMO + 1);
    localparam logic [2:0]    BEAT_SIZE = 3'($clog2(SW));
    localparam logic [1:0]    BURST_INC = 2'b01;
    // The watchdog fires in cycle TMO-1 after the request (r_cnt counts from
    // 0 in the first non-IDLE cycle), so the error ack lands in cycle TMO.
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RRESP,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_sel;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_arvalid;
    logic            r_bready;
    logic            r_rready;
    logic            r_ack;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic [CW-1:0]   r_cnt;
    logic            r_resp_seen;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_ar_hs;
    logic            w_aw_left;
    logic            w_w_left;
    logic            w_ar_left;
    logic            w_b_hs;
    logic            w_r_hs;
    logic            w_tmo;
    logic            w_unused;

    // Handshake and "still pending after this cycle" terms
    assign w_aw_hs   = r_awvalid & AWREADY;
    assign w_w_hs    = r_wvalid  & WREADY;
    assign w_ar_hs   = r_arvalid & ARREADY;
    assign w_aw_left = r_awvalid & ~AWREADY;
    assign w_w_left  = r_wvalid  & ~WREADY;
    assign w_ar_left = r_arvalid & ~ARREADY;
    assign w_b_hs    = r_bready  & BVALID;
    assign w_r_hs    = r_rready  & RVALID;
    assign w_tmo     = (r_cnt == TMO_LAST);

    // IDs and RLAST carry no information for single-beat, ID-0 traffic
    assign w_unused  = ^{BID, RID, RLAST};

    // Main controller: state, registered AXI/system outputs, watchdog
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_resp_seen <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;

            // each VALID drops on its own handshake, whatever the state
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (w_ar_hs) r_arvalid <= 1'b0;

            if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (sys_wen) begin
                        r_addr    <= sys_addr;
                        r_wdata   <= sys_wdata;
                        r_sel     <= sys_sel;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_WRITE;
                    end else if (sys_ren) begin
                        r_addr    <= sys_addr;
                        r_arvalid <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_READ;
                    end
                end

                S_WRITE: begin
                    if (!w_aw_left && !w_w_left) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end else if (w_tmo) begin
                        r_ack       <= 1'b1;
                        r_err       <= 1'b1;
                        r_bready    <= 1'b1;
                        r_resp_seen <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end

                S_WRESP: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        r_ack    <= 1'b1;
                        r_err    <= (BRESP != 2'b00);
                        r_state  <= S_IDLE;
                    end else if (w_tmo) begin
                        r_ack       <= 1'b1;
                        r_err       <= 1'b1;
                        r_resp_seen <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end

                S_READ: begin
                    if (ARREADY) begin
                        r_rready <= 1'b1;
                        r_state  <= S_RRESP;
                    end else if (w_tmo) begin
                        r_ack       <= 1'b1;
                        r_err       <= 1'b1;
                        r_rready    <= 1'b1;
                        r_resp_seen <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end

                S_RRESP: begin
                    if (RVALID) begin
                        r_rdata  <= RDATA;
                        r_rready <= 1'b0;
                        r_ack    <= 1'b1;
                        r_err    <= (RRESP != 2'b00);
                        r_state  <= S_IDLE;
                    end else if (w_tmo) begin
                        r_ack       <= 1'b1;
                        r_err       <= 1'b1;
                        r_resp_seen <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // late response is accepted and thrown away
                    if (w_b_hs || w_r_hs) begin
                        r_resp_seen <= 1'b1;
                        r_bready    <= 1'b0;
                        r_rready    <= 1'b0;
                    end
                    if ((r_resp_seen || w_b_hs || w_r_hs) &&
                        !w_aw_left && !w_w_left && !w_ar_left) begin
                        r_resp_seen <= 1'b0;
                        r_bready    <= 1'b0;
                        r_rready    <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sys_rdata = r_rdata;
    assign sys_ack   = r_ack;
    assign sys_err   = r_err;

    assign AWID      = '0;
    assign AWADDR    = r_addr;
    assign AWLEN     = 4'd0;
    assign AWSIZE    = BEAT_SIZE;
    assign AWBURST   = BURST_INC;
    assign AWVALID   = r_awvalid;

    assign WID       = '0;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_sel;
    assign WLAST     = 1'b1;
    assign WVALID    = r_wvalid;

    assign BREADY    = r_bready;

    assign ARID      = '0;
    assign ARADDR    = r_addr;
    assign ARLEN     = 4'd0;
    assign ARSIZE    = BEAT_SIZE;
    assign ARBURST   = BURST_INC;
    assign ARVALID   = r_arvalid;

    assign RREADY    = r_rready;

endmodule

// File: tb/tb_sys_axi_master.sv
// tb_sys_axi_master: directed scenarios against a configurable AXI slave
// model; expected acks go into a scoreboard popped by a separate monitor.
module tb_sys_axi_master;

    logic        clk;
    logic        rstn;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        sys_err;
    logic [11:0] AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [11:0] WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [11:0] BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [11:0] ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [11:0] RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    sys_axi_master #(.AW(32), .DW(32), .IW(12), .TMO(16)) dut (
        .clk(clk), .rstn(rstn),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
        .sys_wen(sys_wen), .sys_ren(sys_ren),
        .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int ack_count = 0;
    string tag = "reset";

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          req;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] aw_exp[$];
    logic [35:0] w_exp[$];
    logic [31:0] ar_exp[$];
    logic [31:0] last_rdata;

    // slave model configuration
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  bresp_c, rresp_c;
    logic [31:0] rdata_c;

    // slave model state
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, b_pend, r_pend, b_drop, r_drop;
    logic prev_aw_stall, prev_ar_stall;
    logic [31:0] prev_awaddr, prev_araddr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s_%s: actual=0x%0h required=0x%0h", tag, nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s_%s: actual=0x%0h required=none", tag, nm, act);
    endtask

    task automatic cfg(input int awd, input int wd, input int bd, input logic [1:0] br,
                       input int ard, input int rd, input logic [31:0] rdat,
                       input logic [1:0] rr);
        aw_d = awd; w_d = wd; b_d = bd; bresp_c = br;
        ar_d = ard; r_d = rd; rdata_c = rdat; rresp_c = rr;
    endtask

    // drive a one-cycle request and record what the bench expects from it
    task automatic issue(input logic wen, input logic ren, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic axi,
                         input logic want_ack, input logic err,
                         input logic [31:0] edata, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        sys_addr  = a;
        sys_wdata = d;
        sys_sel   = s;
        sys_wen   = wen;
        sys_ren   = ren;
        if (axi) begin
            if (wen) begin
                aw_exp.push_back(a);
                w_exp.push_back({d, s});
            end else if (ren) begin
                ar_exp.push_back(a);
            end
        end
        if (want_ack) begin
            e.err  = err;
            e.data = edata;
            e.lat  = lat;
            e.req  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        sys_wen = 1'b0;
        sys_ren = 1'b0;
    endtask

    task automatic settle(input int extra);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (extra) @(negedge clk);
        chk("pending_acks", 64'(sb.size()), 64'd0);
        chk("pending_beats", 64'(aw_exp.size() + w_exp.size() + ar_exp.size()), 64'd0);
        sb.delete();
        aw_exp.delete();
        w_exp.delete();
        ar_exp.delete();
    endtask

    // AXI slave model and channel monitors, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rstn) begin
            AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
            BVALID = 1'b0; RVALID = 1'b0; BRESP = 2'b00; RRESP = 2'b00;
            RDATA = '0; BID = '0; RID = '0; RLAST = 1'b1;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            b_drop = 1'b0; r_drop = 1'b0;
            prev_aw_stall = 1'b0; prev_ar_stall = 1'b0;
        end else begin
            if (b_drop) begin BVALID = 1'b0; b_drop = 1'b0; end
            if (r_drop) begin RVALID = 1'b0; r_drop = 1'b0; end

            if (b_pend) begin
                if (b_cnt >= b_d) begin
                    BVALID = 1'b1;
                    BRESP  = bresp_c;
                    if (BREADY) begin b_pend = 1'b0; b_drop = 1'b1; end
                end else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_d) begin
                    RVALID = 1'b1;
                    RDATA  = rdata_c;
                    RRESP  = rresp_c;
                    if (RREADY) begin r_pend = 1'b0; r_drop = 1'b1; end
                end else r_cnt++;
            end

            if (prev_aw_stall) chk("aw_stable", {31'd0, AWVALID, AWADDR}, {31'd0, 1'b1, prev_awaddr});
            if (prev_ar_stall) chk("ar_stable", {31'd0, ARVALID, ARADDR}, {31'd0, 1'b1, prev_araddr});

            AWREADY = AWVALID && (aw_cnt >= aw_d);
            if (AWVALID) begin
                if (AWREADY) begin
                    if (aw_exp.size() == 0) flag("unexpected_aw", 64'(AWADDR));
                    else begin
                        chk("awaddr", 64'(AWADDR), 64'(aw_exp.pop_front()));
                        chk("aw_ctl", 64'({AWID, AWLEN, AWSIZE, AWBURST}),
                            64'({12'h000, 4'h0, 3'h2, 2'h1}));
                    end
                    aw_cnt = 0;
                    aw_got = 1'b1;
                end else aw_cnt++;
            end
            WREADY = WVALID && (w_cnt >= w_d);
            if (WVALID) begin
                if (WREADY) begin
                    if (w_exp.size() == 0) flag("unexpected_w", 64'(WDATA));
                    else chk("wbeat", 64'({WDATA, WSTRB, WLAST, WID}),
                             64'({w_exp.pop_front(), 1'b1, 12'h000}));
                    w_cnt = 0;
                    w_got = 1'b1;
                end else w_cnt++;
            end
            if (aw_got && w_got) begin
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
            end
            ARREADY = ARVALID && (ar_cnt >= ar_d);
            if (ARVALID) begin
                if (ARREADY) begin
                    if (ar_exp.size() == 0) flag("unexpected_ar", 64'(ARADDR));
                    else begin
                        chk("araddr", 64'(ARADDR), 64'(ar_exp.pop_front()));
                        chk("ar_ctl", 64'({ARID, ARLEN, ARSIZE, ARBURST}),
                            64'({12'h000, 4'h0, 3'h2, 2'h1}));
                    end
                    ar_cnt = 0;
                    r_pend = 1'b1;
                    r_cnt  = 0;
                end else ar_cnt++;
            end

            prev_aw_stall = AWVALID && !AWREADY;
            prev_awaddr   = AWADDR;
            prev_ar_stall = ARVALID && !ARREADY;
            prev_araddr   = ARADDR;
        end
    end

    // system-bus response monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        exp_t e;
        if (rstn && sys_ack) begin
            ack_count++;
            if (sb.size() == 0) flag("unexpected_ack", 64'({sys_err, sys_rdata}));
            else begin
                e = sb.pop_front();
                chk("ack_err", 64'(sys_err), 64'(e.err));
                chk("ack_rdata", 64'(sys_rdata), 64'(e.data));
                chk("ack_latency", 64'(cyc - e.req), 64'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n0;
        rstn = 1'b0;
        sys_addr = '0; sys_wdata = '0; sys_sel = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        last_rdata = 32'h0;
        cfg(0, 0, 0, 2'd0, 0, 0, 32'h0, 2'd0);
        repeat (3) @(negedge clk);
        chk("outputs", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, sys_ack, sys_err, sys_rdata}), 64'd0);
        chk("payload", 64'({AWADDR, WDATA}), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        tag = "t1_write";
        cfg(0, 0, 0, 2'd0, 0, 0, 32'h0, 2'd0);
        issue(1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1, 0, last_rdata, 3);
        settle(4);

        tag = "t2_read_stall";
        cfg(0, 0, 0, 2'd0, 5, 0, 32'h1234_5678, 2'd0);
        last_rdata = 32'h1234_5678;
        issue(0, 1, 32'h4000_0020, 32'h0, 4'h0, 1, 1, 0, last_rdata, 8);
        settle(4);

        tag = "t3_w_first";
        cfg(4, 0, 0, 2'd0, 0, 0, 32'h0, 2'd0);
        n0 = ack_count;
        issue(1, 0, 32'h4000_0030, 32'hA5A5_0F0F, 4'h3, 1, 1, 0, last_rdata, 7);
        @(negedge clk);
        @(negedge clk);
        chk("valids_after_w", 64'({AWVALID, WVALID}), 64'b10);
        settle(4);
        chk("ack_count", 64'(ack_count - n0), 64'd1);

        tag = "t4_slverr";
        cfg(0, 0, 0, 2'd0, 0, 0, 32'hBAD0_BAD0, 2'd2);
        last_rdata = 32'hBAD0_BAD0;
        issue(0, 1, 32'h4000_0034, 32'h0, 4'h0, 1, 1, 1, last_rdata, 3);
        settle(4);

        tag = "t5_wen_ren";
        cfg(0, 0, 0, 2'd0, 0, 0, 32'h7777_7777, 2'd0);
        issue(1, 1, 32'h4000_0070, 32'hCAFE_F00D, 4'hC, 1, 1, 0, last_rdata, 3);
        settle(6);

        tag = "t6_timeout_drain";
        cfg(0, 0, 40, 2'd0, 0, 0, 32'h0, 2'd0);
        n0 = ack_count;
        issue(1, 0, 32'h4000_0060, 32'h1111_2222, 4'hF, 1, 1, 1, last_rdata, 16);
        repeat (18) @(posedge clk);
        issue(0, 1, 32'h5000_0000, 32'h0, 4'h0, 0, 0, 0, last_rdata, 0);
        repeat (40) @(posedge clk);
        settle(2);
        chk("ack_count", 64'(ack_count - n0), 64'd1);

        tag = "t6_resp_at_limit";
        cfg(0, 0, 13, 2'd0, 0, 0, 32'h0, 2'd0);
        issue(1, 0, 32'h4000_0064, 32'h3333_4444, 4'hF, 1, 1, 0, last_rdata, 16);
        settle(4);

        tag = "t6_resp_past_limit";
        cfg(0, 0, 14, 2'd0, 0, 0, 32'h0, 2'd0);
        n0 = ack_count;
        issue(1, 0, 32'h4000_0068, 32'h5555_6666, 4'hF, 1, 1, 1, last_rdata, 16);
        settle(6);
        chk("ack_count", 64'(ack_count - n0), 64'd1);

        tag = "t7_reset_rresp";
        cfg(0, 0, 0, 2'd0, 0, 10, 32'hFFFF_0000, 2'd0);
        issue(0, 1, 32'h4000_0040, 32'h0, 4'h0, 1, 0, 0, last_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_rready", 64'(RREADY), 64'd1);
        n0 = ack_count;
        #1 rstn = 1'b0;
        #1;
        chk("outputs", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, sys_ack, sys_err, sys_rdata}), 64'd0);
        chk("payload", 64'({AWADDR, WDATA}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        last_rdata = 32'h0;
        repeat (15) @(posedge clk);
        chk("no_ack_after_release", 64'(ack_count - n0), 64'd0);
        cfg(0, 0, 0, 2'd0, 0, 0, 32'h0BAD_F00D, 2'd0);
        last_rdata = 32'h0BAD_F00D;
        issue(0, 1, 32'h4000_0050, 32'h0, 4'h0, 1, 1, 0, last_rdata, 3);
        settle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
